booth_r4_mac_seq: RTL and testbench

//  Parametrised sequential radix-4 Booth multiplier / multiply-accumulate unit.

---
 rtl/booth_r4_pkg.sv | 22 ++
 rtl/booth_r4_mac_seq_if.sv | 24 ++
 rtl/booth_r4_pp_sel.sv | 28 ++
 rtl/booth_r4_mac_seq.sv | 125 ++++++++++++
 tb/tb_booth_r4_mac_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiply-accumulate unit:
// FSM state encoding, Booth digit encoding and the digit decoder.
package booth_r4_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

    // Window is {x[2i+1], x[2i], x[2i-1]}.
    function automatic digit_t booth_decode(input logic [2:0] bits);
        digit_t d;
        case (bits)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_mac_seq_if.sv
// Begin/ready handshake and operand/result bus between the sequencing
// controller (master) and the Booth MAC (slave).
interface booth_r4_mac_seq_if #(
    parameter int WIDTH = 16
);
    logic                   begin_mul;
    logic                   signed_mode;
    logic                   acc_mode;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       X;
    logic                   busy;
    logic                   ready;
    logic [2*WIDTH-1:0]     out_p;

    modport master (
        output begin_mul, signed_mode, acc_mode, A, X,
        input  busy, ready, out_p
    );

    modport slave (
        input  begin_mul, signed_mode, acc_mode, A, X,
        output busy, ready, out_p
    );
endinterface

// File: rtl/booth_r4_pp_sel.sv
// Booth partial-product selector: digit * A_ext with one extra bit so that
// +-2*A of the most-negative / largest unsigned operand stays exact.
module booth_r4_pp_sel
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  digit_t                   digit,
    input  logic signed [WIDTH+1:0]  a_ext,
    output logic signed [WIDTH+2:0]  pp
);

    logic signed [WIDTH+2:0] a_w;

    assign a_w = {a_ext[WIDTH+1], a_ext};

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = a_w;
            POS2:    pp = a_w <<< 1;
            NEG1:    pp = -a_w;
            NEG2:    pp = -(a_w <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mac_seq.sv
// Sequential radix-4 Booth multiplier / accumulator: one Booth digit per cycle,
// fixed latency of ITER cycles from accept to ready, optional accumulate.
module booth_r4_mac_seq
    import booth_r4_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH / 2 + 1,
    parameter int CNT_W = $clog2(ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_r4_mac_seq_if.slave    bus
);

    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 4;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0]    a_q, a_d;
    logic [AW:0]             x_q, x_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    acc_q, acc_d;
    logic [2*WIDTH-1:0]      out_p_q, out_p_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;

    digit_t                  digit;
    logic signed [WIDTH+2:0] pp;
    logic signed [PW-1:0]    pp_ext;
    logic signed [PW-1:0]    prod_sum;
    logic signed [PW-1:0]    prod_shift;
    logic [AW-1:0]           a_ext_in;
    logic [AW-1:0]           x_ext_in;
    logic                    last_iter;

    // x_q carries the implicit x[-1]=0 in bit 0, so the low 3 bits are the window.
    assign digit = booth_decode(x_q[2:0]);

    booth_r4_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .digit (digit),
        .a_ext (a_q),
        .pp    (pp)
    );

    // Adding at bit AW makes the ITER right-shifts land the product at bit 0.
    assign pp_ext     = PW'(pp);
    assign prod_sum   = prod_q + (pp_ext <<< AW);
    assign prod_shift = prod_sum >>> 2;

    assign a_ext_in  = bus.signed_mode ? {{2{bus.A[WIDTH-1]}}, bus.A} : {2'b00, bus.A};
    assign x_ext_in  = bus.signed_mode ? {{2{bus.X[WIDTH-1]}}, bus.X} : {2'b00, bus.X};
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        x_d     = x_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        out_p_d = out_p_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.begin_mul) begin
                    state_d = CALC;
                    a_d     = a_ext_in;
                    x_d     = {x_ext_in, 1'b0};
                    prod_d  = '0;
                    cnt_d   = '0;
                    acc_d   = bus.acc_mode;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            CALC: begin
                prod_d = prod_shift;
                x_d    = {2'b00, x_q[AW:2]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    out_p_d = prod_shift[2*WIDTH-1:0] + (acc_q ? out_p_q : '0);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            x_q     <= '0;
            prod_q  <= '0;
            acc_q   <= 1'b0;
            out_p_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            x_q     <= x_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            out_p_q <= out_p_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;
    assign bus.out_p = out_p_q;

endmodule

// File: tb/tb_booth_r4_mac_seq.sv
// Bench for booth_r4_mac_seq: directed WIDTH=16 vector table plus corner
// sequences, then randomised WIDTH=8 ops against an arithmetic reference.
module tb_booth_r4_mac_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    booth_r4_mac_seq_if #(.WIDTH(16)) bus16 ();
    booth_r4_mac_seq_if #(.WIDTH(8))  bus8 ();

    booth_r4_mac_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    booth_r4_mac_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        sm;
        logic        am;
        logic [15:0] a;
        logic [15:0] x;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One WIDTH=16 op; optionally pokes begin_mul with other operands mid-CALC.
    task automatic op16(input logic sm, input logic am, input logic [15:0] a, input logic [15:0] x,
                        input int poke, output logic [31:0] res, output int lat,
                        output int busy_n, output bit held_ok);
        logic [31:0] prev;
        @(negedge clk);
        bus16.signed_mode = sm;
        bus16.acc_mode    = am;
        bus16.A           = a;
        bus16.X           = x;
        bus16.begin_mul   = 1'b1;
        prev              = bus16.out_p;
        @(posedge clk); #1;
        bus16.begin_mul = 1'b0;
        lat     = 0;
        busy_n  = 0;
        held_ok = 1'b1;
        while (!bus16.ready && lat < 40) begin
            if (bus16.busy) busy_n++;
            if (bus16.out_p !== prev) held_ok = 1'b0;
            if (lat == poke) begin
                bus16.begin_mul   = 1'b1;
                bus16.A           = 16'h0007;
                bus16.X           = 16'h0003;
                bus16.signed_mode = ~sm;
                bus16.acc_mode    = ~am;
            end else begin
                bus16.begin_mul = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus16.begin_mul = 1'b0;
        res = bus16.out_p;
    endtask

    task automatic op8(input logic sm, input logic am, input logic [7:0] a, input logic [7:0] x,
                       output logic [15:0] res, output int lat);
        @(negedge clk);
        bus8.signed_mode = sm;
        bus8.acc_mode    = am;
        bus8.A           = a;
        bus8.X           = x;
        bus8.begin_mul   = 1'b1;
        @(posedge clk); #1;
        bus8.begin_mul = 1'b0;
        bus8.A         = ~a;
        lat = 0;
        while (!bus8.ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus8.out_p;
    endtask

    function automatic logic [7:0] pick8();
        logic [7:0] v;
        case ($urandom_range(0, 7))
            0:       v = 8'h80;
            1:       v = 8'h7F;
            2:       v = 8'hFF;
            3:       v = 8'h00;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [15:0] res8;
        logic [15:0] model8;
        int          lat;
        int          busy_n;
        bit          held_ok;
        logic        sm;
        logic        am;
        logic [7:0]  a8;
        logic [7:0]  x8;
        longint      av;
        longint      xv;

        vecs[0] = '{"t1_neg17x9",      1'b1, 1'b0, 16'hFFEF, 16'h0009, 32'hFFFFFF67};
        vecs[1] = '{"t4_acc_3x4",      1'b1, 1'b1, 16'h0003, 16'h0004, 32'hFFFFFF73};
        vecs[2] = '{"t4_noacc_2x5",    1'b1, 1'b0, 16'h0002, 16'h0005, 32'h0000000A};
        vecs[3] = '{"t2_uns_ffff",     1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[4] = '{"t2_sgn_ffff",     1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[5] = '{"t3_minxmin",      1'b1, 1'b0, 16'h8000, 16'h8000, 32'h40000000};
        vecs[6] = '{"t3_minxmax",      1'b1, 1'b0, 16'h8000, 16'h7FFF, 32'hC0008000};

        bus16.begin_mul = 1'b0; bus16.signed_mode = 1'b0; bus16.acc_mode = 1'b0;
        bus16.A = '0; bus16.X = '0;
        bus8.begin_mul = 1'b0; bus8.signed_mode = 1'b0; bus8.acc_mode = 1'b0;
        bus8.A = '0; bus8.X = '0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy16",  bus16.busy,  0);
        chk("rst_ready16", bus16.ready, 0);
        chk("rst_out16",   bus16.out_p, 0);
        chk("rst_busy8",   bus8.busy,   0);
        chk("rst_ready8",  bus8.ready,  0);
        chk("rst_out8",    bus8.out_p,  0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            op16(vecs[i].sm, vecs[i].am, vecs[i].a, vecs[i].x, -1, res, lat, busy_n, held_ok);
            $display("op16 %s sm=%0b am=%0b A=%h X=%h out=%h lat=%0d",
                     vecs[i].name, vecs[i].sm, vecs[i].am, vecs[i].a, vecs[i].x, res, lat);
            chk({vecs[i].name, "_lat"},   lat,     9);
            chk({vecs[i].name, "_busy"},  busy_n,  9);
            chk({vecs[i].name, "_stable"}, held_ok, 1);
            chk(vecs[i].name,             res,     vecs[i].exp);
            repeat (3) @(posedge clk);
            #1;
            chk({vecs[i].name, "_hold_ready"}, bus16.ready, 1);
            chk({vecs[i].name, "_hold_out"},   bus16.out_p, vecs[i].exp);
        end

        // begin_mul with new operands during CALC must be ignored
        op16(1'b1, 1'b0, 16'd5, 16'd6, 3, res, lat, busy_n, held_ok);
        $display("op16 t5_ignore A=0005 X=0006 out=%h lat=%0d", res, lat);
        chk("t5_ignore_lat", lat, 9);
        chk("t5_ignore_out", res, 32'd30);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_ignore_hold", bus16.out_p, 32'd30);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus16.signed_mode = 1'b1; bus16.acc_mode = 1'b0;
        bus16.A = 16'd9; bus16.X = 16'd9; bus16.begin_mul = 1'b1;
        @(posedge clk); #1;
        bus16.begin_mul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_pre_rst_busy", bus16.busy, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_rst_busy",  bus16.busy,  0);
        chk("t5_rst_ready", bus16.ready, 0);
        chk("t5_rst_out",   bus16.out_p, 0);
        $display("op16 t5_reset_mid_calc busy=%0b ready=%0b out=%h",
                 bus16.busy, bus16.ready, bus16.out_p);
        @(negedge clk);
        rst = 1'b1;

        op16(1'b1, 1'b1, 16'd3, 16'd4, -1, res, lat, busy_n, held_ok);
        $display("op16 acc_after_reset A=0003 X=0004 out=%h lat=%0d", res, lat);
        chk("acc_after_rst_lat", lat, 9);
        chk("acc_after_rst_out", res, 32'd12);

        // randomised WIDTH=8 ops vs plain arithmetic, wrapping at 16 bits
        model8 = '0;
        for (int i = 0; i < 500; i++) begin
            sm = 1'($urandom_range(0, 1));
            am = 1'(i % 2);
            a8 = pick8();
            x8 = pick8();
            av = sm ? longint'($signed(a8)) : longint'(a8);
            xv = sm ? longint'($signed(x8)) : longint'(x8);
            model8 = 16'((am ? longint'(model8) : 64'sd0) + av * xv);
            op8(sm, am, a8, x8, res8, lat);
            $display("op8 %0d sm=%0b am=%0b A=%h X=%h out=%h lat=%0d", i, sm, am, a8, x8, res8, lat);
            chk("rand8_lat", lat, 5);
            chk("rand8_out", res8, model8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
